// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: commit-stage trap/mret events and CSR targets in,
// pipeline flush/hold and fetch redirect out.
interface trap_sequencer_if #(
    parameter int unsigned XLEN = 64
);
    logic            trap_req;
    logic            trap_is_int;
    logic [5:0]      trap_cause;
    logic            mret_req;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            ibus_busy;
    logic            dbus_busy;
    logic            flush;
    logic            csr_hold;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;
    logic            drain_timeout;
    logic [31:0]     trap_count;

    // Commit/CSR side: raises events, observes the sequencer.
    modport master (
        output trap_req, trap_is_int, trap_cause, mret_req, mtvec, mepc,
               ibus_busy, dbus_busy,
        input  flush, csr_hold, redirect_valid, redirect_pc, busy,
               drain_timeout, trap_count
    );

    // Sequencer side.
    modport slave (
        input  trap_req, trap_is_int, trap_cause, mret_req, mtvec, mepc,
               ibus_busy, dbus_busy,
        output flush, csr_hold, redirect_valid, redirect_pc, busy,
               drain_timeout, trap_count
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap sequencer: on a committed trap or mret, flushes the pipeline, waits for
// outstanding bus traffic to drain (bounded), then issues one PC redirect.
module trap_sequencer #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DRAIN_MAX   = 16,
    parameter bit          VECTORED_EN = 1'b1
) (
    input logic              i_clk,
    input logic              i_reset,
    trap_sequencer_if.slave  bus
);
    // Wide enough to hold DRAIN_MAX-1 even when DRAIN_MAX is 1.
    localparam int unsigned CntW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StDrain    = 2'd1,
        StRedirect = 2'd2
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [XLEN-1:0] r_target;
    logic            r_is_trap;
    logic            r_busy;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_drain_timeout;
    logic [31:0]     r_trap_count;

    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_vec_offset;
    logic            w_vectored;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] w_mret_target;
    logic [XLEN-1:0] w_new_target;
    logic            w_bus_busy;
    logic            w_cnt_last;

    // Redirect target selection; MODE 2/3 fall back to direct.
    always_comb begin
        w_trap_base   = {bus.mtvec[XLEN-1:2], 2'b00};
        w_vec_offset  = XLEN'({bus.trap_cause, 2'b00});
        w_vectored    = VECTORED_EN && (bus.mtvec[1:0] == 2'b01) && bus.trap_is_int;
        w_trap_target = w_vectored ? (w_trap_base + w_vec_offset) : w_trap_base;
        w_mret_target = {bus.mepc[XLEN-1:2], 2'b00};
        // A simultaneous trap wins over mret.
        w_new_target  = bus.trap_req ? w_trap_target : w_mret_target;
        w_bus_busy    = bus.ibus_busy | bus.dbus_busy;
        w_cnt_last    = (r_cnt == CntW'(DRAIN_MAX - 1));
    end

    // Sequencer FSM with registered outputs; redirect_valid/pc are set on entry to StRedirect.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= StIdle;
            r_cnt            <= '0;
            r_target         <= '0;
            r_is_trap        <= 1'b0;
            r_busy           <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_drain_timeout  <= 1'b0;
            r_trap_count     <= '0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            unique case (r_state)
                StIdle: begin
                    if (bus.trap_req || bus.mret_req) begin
                        r_target  <= w_new_target;
                        r_is_trap <= bus.trap_req;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (w_bus_busy) begin
                            r_state <= StDrain;
                        end else begin
                            r_state          <= StRedirect;
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= w_new_target;
                        end
                    end
                end
                StDrain: begin
                    if (!w_bus_busy || w_cnt_last) begin
                        r_state          <= StRedirect;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_target;
                        if (w_bus_busy) begin
                            r_drain_timeout <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRedirect: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    if (r_is_trap) begin
                        r_trap_count <= r_trap_count + 32'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flush          = r_busy;
    assign bus.csr_hold       = r_busy;
    assign bus.busy           = r_busy;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.drain_timeout  = r_drain_timeout;
    assign bus.trap_count     = r_trap_count;
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer (DRAIN_MAX=8). Inputs change and outputs
// are sampled on the falling edge.
module tb_trap_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    trap_sequencer_if #(.XLEN(64)) bus_if ();

    trap_sequencer #(
        .XLEN       (64),
        .DRAIN_MAX  (8),
        .VECTORED_EN(1'b1)
    ) u_dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [31:0] count, input logic tmo);
        check({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
        check({tag, "_flush"}, 64'(bus_if.flush), 64'd0);
        check({tag, "_rv"}, 64'(bus_if.redirect_valid), 64'd0);
        check({tag, "_pc"}, bus_if.redirect_pc, 64'd0);
        check({tag, "_count"}, 64'(bus_if.trap_count), 64'(count));
        check({tag, "_tmo"}, 64'(bus_if.drain_timeout), 64'(tmo));
    endtask

    task automatic check_redirect(input string tag, input logic [63:0] pc);
        check({tag, "_rv"}, 64'(bus_if.redirect_valid), 64'd1);
        check({tag, "_pc"}, bus_if.redirect_pc, pc);
        check({tag, "_flush"}, 64'(bus_if.flush), 64'd1);
        check({tag, "_hold"}, 64'(bus_if.csr_hold), 64'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus_if.trap_req    = 1'b0;
        bus_if.trap_is_int = 1'b0;
        bus_if.trap_cause  = 6'd0;
        bus_if.mret_req    = 1'b0;
        bus_if.mtvec       = 64'd0;
        bus_if.mepc        = 64'd0;
        bus_if.ibus_busy   = 1'b0;
        bus_if.dbus_busy   = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_idle("reset", 32'd0, 1'b0);

        // 1: direct trap, buses idle.
        bus_if.mtvec    = 64'h8000_0100;
        bus_if.trap_req = 1'b1;
        step();
        bus_if.trap_req = 1'b0;
        check_redirect("t1", 64'h8000_0100);
        step();
        check_idle("t1_after", 32'd1, 1'b0);

        // 2: vectored interrupt, accepted back-to-back in the idle cycle after each redirect.
        bus_if.mtvec       = 64'h8000_0001;
        bus_if.trap_is_int = 1'b1;
        bus_if.trap_cause  = 6'd7;
        bus_if.trap_req    = 1'b1;
        step();
        bus_if.trap_req = 1'b0;
        check_redirect("t2_vec", 64'h8000_001C);
        step();
        check("t2_idle", 64'(bus_if.busy), 64'd0);
        bus_if.trap_is_int = 1'b0;
        bus_if.trap_req    = 1'b1;
        step();
        bus_if.trap_req = 1'b0;
        check_redirect("t2_exc", 64'h8000_0000);
        step();
        // Vector offset wraps modulo 2^64.
        bus_if.mtvec       = 64'hFFFF_FFFF_FFFF_FFF1;
        bus_if.trap_is_int = 1'b1;
        bus_if.trap_cause  = 6'd63;
        bus_if.trap_req    = 1'b1;
        step();
        bus_if.trap_req = 1'b0;
        check_redirect("t2_wrap", 64'h0000_0000_0000_00EC);
        step();
        // MODE 3 is treated as direct.
        bus_if.mtvec      = 64'h8000_0003;
        bus_if.trap_cause = 6'd7;
        bus_if.trap_req   = 1'b1;
        step();
        bus_if.trap_req    = 1'b0;
        bus_if.trap_is_int = 1'b0;
        check_redirect("t2_mode3", 64'h8000_0000);
        step();
        check_idle("t2_after", 32'd5, 1'b0);

        // 3: mret with dbus busy for three more cycles; low mepc bits dropped.
        bus_if.mepc      = 64'h8000_0043;
        bus_if.mret_req  = 1'b1;
        bus_if.dbus_busy = 1'b1;
        step();
        bus_if.mret_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_drain%0d_flush", i), 64'(bus_if.flush), 64'd1);
            check($sformatf("t3_drain%0d_rv", i), 64'(bus_if.redirect_valid), 64'd0);
            if (i == 2) bus_if.dbus_busy = 1'b0;
            step();
        end
        check_redirect("t3", 64'h8000_0040);
        step();
        check_idle("t3_after", 32'd5, 1'b0);

        // 4: stuck dbus forces a timeout after 8 DRAIN cycles; a trap during DRAIN is ignored.
        bus_if.mtvec     = 64'h100;
        bus_if.dbus_busy = 1'b1;
        bus_if.trap_req  = 1'b1;
        step();
        bus_if.mtvec = 64'h900;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus_if.trap_req = 1'b0;
            check($sformatf("t4_drain%0d_busy", i), 64'(bus_if.busy), 64'd1);
            check($sformatf("t4_drain%0d_rv", i), 64'(bus_if.redirect_valid), 64'd0);
            check($sformatf("t4_drain%0d_tmo", i), 64'(bus_if.drain_timeout), 64'd0);
            step();
        end
        check_redirect("t4", 64'h100);
        check("t4_tmo", 64'(bus_if.drain_timeout), 64'd1);
        step();
        bus_if.dbus_busy = 1'b0;
        check_idle("t4_after", 32'd6, 1'b1);
        step();
        check_idle("t4_quiet", 32'd6, 1'b1);

        // 5: simultaneous trap and mret, trap wins.
        bus_if.mtvec    = 64'h100;
        bus_if.mepc     = 64'h200;
        bus_if.trap_req = 1'b1;
        bus_if.mret_req = 1'b1;
        step();
        bus_if.trap_req = 1'b0;
        bus_if.mret_req = 1'b0;
        check_redirect("t5", 64'h100);
        step();
        check_idle("t5_after", 32'd7, 1'b1);

        // 6: reset while in DRAIN.
        bus_if.ibus_busy = 1'b1;
        bus_if.trap_req  = 1'b1;
        step();
        bus_if.trap_req = 1'b0;
        check("t6_in_drain", 64'(bus_if.busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus_if.ibus_busy = 1'b0;
        check_idle("t6_reset", 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t6_norv%0d", i), 64'(bus_if.redirect_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
